// File: rtl/mem_stage_controller_pkg.sv
// Shared types and defaults for the memory-stage controller.
// Holds the FSM encoding and the default SRAM geometry and timing.
package mem_stage_controller_pkg;

    localparam int PKG_ADDR_W      = 32;
    localparam int PKG_SRAM_ADDR_W = 18;
    localparam int PKG_WAIT_CYCLES = 5;
    localparam int PKG_BASE_ADDR   = 1024;
    localparam int PKG_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/mem_stage_controller_counter.sv
// Wait-state counter for the SRAM access window.
// Raises o_tc while the count equals WAIT_CYCLES-1.
module wait_state_counter
    import mem_stage_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = PKG_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [PKG_CNT_W-1:0] r_cnt;

    // Clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + PKG_CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == PKG_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_controller.sv
// Memory-stage controller: turns a one-cycle load/store request into a
// fixed-latency SRAM access and freezes the pipeline until it completes.
module mem_stage_controller
    import mem_stage_controller_pkg::*;
#(
    parameter int ADDR_W      = PKG_ADDR_W,
    parameter int SRAM_ADDR_W = PKG_SRAM_ADDR_W,
    parameter int WAIT_CYCLES = PKG_WAIT_CYCLES,
    parameter int BASE_ADDR   = PKG_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_W_EN,
    input  logic                   MEM_R_EN,
    input  logic [ADDR_W-1:0]      address,
    input  logic [ADDR_W-1:0]      wdata,
    output logic [ADDR_W-1:0]      rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [ADDR_W-1:0]      SRAM_DQ_out,
    output logic                   SRAM_DQ_OE,
    input  logic [ADDR_W-1:0]      SRAM_DQ_in,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    state_e r_state;
    state_e w_next;

    logic                   w_req;
    logic [ADDR_W-1:0]      w_offset;
    logic [SRAM_ADDR_W-1:0] w_sram_addr;

    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0]      r_wdata;
    logic [ADDR_W-1:0]      r_rdata;
    logic                   r_is_write;

    logic w_ready;
    logic w_we_n;
    logic w_oe_n;
    logic w_dq_oe;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_tc;
    logic w_start;
    logic w_capture;

    assign w_req       = MEM_W_EN | MEM_R_EN;
    assign w_offset    = address - LP_BASE;
    assign w_sram_addr = SRAM_ADDR_W'(w_offset >> 2);

    wait_state_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_clr(w_cnt_clr),
        .i_en (w_cnt_en),
        .o_tc (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; strobes depend only on state and latched op.
    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_we_n    = 1'b1;
        w_oe_n    = 1'b1;
        w_dq_oe   = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        w_start   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready   = ~w_req;
                w_cnt_clr = 1'b1;
                if (w_req) begin
                    w_start = 1'b1;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_cnt_en = 1'b1;
                if (r_is_write) begin
                    w_we_n  = 1'b0;
                    w_dq_oe = 1'b1;
                end else begin
                    w_oe_n = 1'b0;
                end
                if (w_tc) begin
                    w_capture = ~r_is_write;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                // The request still on the inputs is the one just served.
                w_ready = 1'b1;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the request in IDLE and capture read data at the end of a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_start) begin
                r_addr     <= w_sram_addr;
                r_wdata    <= wdata;
                r_is_write <= MEM_W_EN;
            end
            if (w_capture) begin
                r_rdata <= SRAM_DQ_in;
            end
        end
    end

    assign ready       = rst | w_ready;
    assign rdata       = r_rdata;
    assign SRAM_ADDR   = r_addr;
    assign SRAM_DQ_out = r_wdata;
    assign SRAM_DQ_OE  = w_dq_oe;
    assign SRAM_WE_N   = w_we_n;
    assign SRAM_OE_N   = w_oe_n;

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
Sequences the memory stage for the EX/MEM pipeline register outputs. Converts a one-cycle-wide load/store request (address, store data, read/write enables) into a fixed-latency access on an external single-port synchronous SRAM. Drives `ready` so the pipeline freezes until the access completes. Sits between the EX/MEM register and the MEM/WB register; `~ready` feeds the freeze input of every pipeline register.

Parameters:
- ADDR_W, 32, width of CPU address and data (`ADDRESS_LEN`)
- SRAM_ADDR_W, 18, SRAM word-address width
- WAIT_CYCLES, 5, SRAM access cycles per transfer; legal range 1..15
- BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MEM_W_EN  in  1  store request, from EX/MEM register
- MEM_R_EN  in  1  load request, from EX/MEM register
- address  in  ADDR_W  byte address (ALU result)
- wdata  in  ADDR_W  store data (Val_Rm)
- rdata  out  ADDR_W  load result, registered
- ready  out  1  high = pipeline may advance; low = freeze
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM word address
- SRAM_DQ_out  out  ADDR_W  SRAM write data
- SRAM_DQ_OE  out  1  write-data bus drive enable
- SRAM_DQ_in  in  ADDR_W  SRAM read data
- SRAM_WE_N  out  1  active-low write strobe
- SRAM_OE_N  out  1  active-low output enable

Behaviour:
- One clock and one reset. `rst` is asynchronous and active-high.
- Reset values: state IDLE, counter 0, rdata 0, SRAM_ADDR 0, SRAM_DQ_out 0, SRAM_DQ_OE 0, SRAM_WE_N 1, SRAM_OE_N 1. `ready` reads 1 while in reset.
- `req = MEM_W_EN | MEM_R_EN`. `is_write = MEM_W_EN`; when both enables are high, the request is a write.
- Address translation: `SRAM_ADDR = ((address - BASE_ADDR) >> 2)[SRAM_ADDR_W-1:0]`. The subtraction is modulo 2^ADDR_W. No range check; addresses wrap.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `ready = ~req`, combinational, so the pipeline freezes in the same cycle the request appears.
  - On `req`: latch SRAM address, wdata and op; counter <= 0; go to ACCESS.
- ACCESS:
  - ready = 0. SRAM_ADDR holds the latched address.
  - Write: SRAM_WE_N = 0, SRAM_DQ_OE = 1, SRAM_DQ_out = latched wdata.
  - Read: SRAM_OE_N = 0.
  - Counter increments each cycle. When counter == WAIT_CYCLES-1, go to DONE; on a read, also capture SRAM_DQ_in into rdata.
- DONE:
  - ready = 1; all strobes inactive (WE_N = OE_N = 1, DQ_OE = 0). Go to IDLE unconditionally.
  - The request still present on the inputs this cycle is the one just served. It must not be restarted.
- Latency: request seen in cycle 0 → ACCESS in cycles 1..WAIT_CYCLES → DONE in cycle WAIT_CYCLES+1, with ready = 1 and rdata valid. A new request can start no earlier than cycle WAIT_CYCLES+2.
- rdata holds its value until the next read completes. Writes never modify rdata.
- Request inputs are sampled only in IDLE. Changes to them during ACCESS or DONE are ignored.
- Reset mid-access: all outputs return immediately to reset values. The interrupted write is not completed and rdata is cleared.
- All SRAM-side outputs are driven from registers or from the state only, never combinationally from CPU inputs.

Decomposition:
- Shared configs/package:
  - state encodings (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10)
  - default WAIT_CYCLES and BASE_ADDR
  - SRAM_ADDR_W
- One sub-module, `wait_state_counter`: 4-bit counter with clear, enable and terminal-count output (`tc` at WAIT_CYCLES-1), asynchronous active-high reset.

Test Plan:
All scenarios use WAIT_CYCLES = 5 and BASE_ADDR = 1024.
- Reset: hold rst high, then release with no request → ready = 1, SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ_OE = 0, rdata = 0.
- Store: MEM_W_EN = 1, address = 1032, wdata = 0xDEADBEEF held → ready = 0 in cycles 0–5; SRAM_ADDR = 2, SRAM_WE_N = 0, SRAM_DQ_OE = 1 in cycles 1–5; ready = 1 in cycle 6; exactly 5 WE_N-low cycles.
- Load: after the store, MEM_R_EN = 1, address = 1032, SRAM model returns the stored word → SRAM_OE_N = 0 in cycles 1–5; rdata = 0xDEADBEEF and ready = 1 in cycle 6; rdata stable afterwards.
- Back-to-back: load to 1036 immediately followed by store to 1040 (pipeline advances on ready) → second access enters ACCESS in cycle 8, not cycle 7; SRAM_ADDR = 3, then 4; no duplicated first access.
- Both enables: MEM_W_EN = MEM_R_EN = 1, address = 1024, wdata = 0x12345678 → treated as a write: WE_N pulses, OE_N stays 1, rdata unchanged.
- Reset mid-write: assert rst in cycle 3 of a store → same cycle: SRAM_WE_N = 1, SRAM_DQ_OE = 0, rdata = 0; after release, FSM is in IDLE and ready = ~req.
